// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timer definitions for input_capture and output_compare
package timer_pkg;

  localparam int TIMER_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_SET    = 2'b01,
    MODE_CLEAR  = 2'b10,
    MODE_PWM    = 2'b11
  } oc_mode_e;

endpackage

// File: rtl/output_compare_if.sv
// rtl/output_compare_if.sv - control and status bundle of the output-compare channel
interface output_compare_if
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) ();

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] cmpVal;
  logic [WIDTH-1:0] period;
  logic             load;
  logic [WIDTH-1:0] cnt;
  logic             sig;
  logic             intFlag;
  logic             rstIntFlag;
  logic             wrap;

  modport master (
    output en, mode, cmpVal, period, load, rstIntFlag,
    input  cnt, sig, intFlag, wrap
  );

  modport slave (
    input  en, mode, cmpVal, period, load, rstIntFlag,
    output cnt, sig, intFlag, wrap
  );

endinterface

// File: rtl/oc_shadow_reg.sv
// rtl/oc_shadow_reg.sv - double-buffered compare/period registers
// Pending values move to active immediately while stopped, otherwise only on a wrap edge.
module oc_shadow_reg
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] cmp_in,
  input  logic [WIDTH-1:0] period_in,
  input  logic             wrap_edge,
  output logic [WIDTH-1:0] active_cmp,
  output logic [WIDTH-1:0] active_period
);

  logic [WIDTH-1:0] pending_cmp;
  logic [WIDTH-1:0] pending_period;
  logic             pending_valid;
  logic             transfer;

  assign transfer = pending_valid && (!en || wrap_edge);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_cmp    <= '0;
      pending_period <= '0;
      pending_valid  <= 1'b0;
      active_cmp     <= '0;
      active_period  <= '1;
    end else begin
      if (transfer) begin
        active_cmp     <= pending_cmp;
        active_period  <= pending_period;
        pending_valid  <= 1'b0;
      end
      // A load on the transfer edge is kept for the next wrap, not this one.
      if (load) begin
        pending_cmp    <= cmp_in;
        pending_period <= period_in;
        pending_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_compare.sv
// rtl/output_compare.sv - timer output-compare / PWM generator
// Free-running counter vs double-buffered compare drives sig and a sticky match flag.
module output_compare
  import timer_pkg::*;
#(
  parameter int   WIDTH       = TIMER_WIDTH,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  output_compare_if.slave    bus
);

  logic [WIDTH-1:0] cnt_q;
  logic             sig_q;
  logic             int_q;
  logic             wrap_q;
  logic [WIDTH-1:0] active_cmp;
  logic [WIDTH-1:0] active_period;
  logic             wrap_edge;
  logic             match;
  oc_mode_e         mode_sel;

  assign mode_sel  = oc_mode_e'(bus.mode);
  assign wrap_edge = bus.en && (cnt_q == active_period);
  assign match     = bus.en && (cnt_q == active_cmp);

  oc_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
    .clk           (clk),
    .rst           (rst),
    .en            (bus.en),
    .load          (bus.load),
    .cmp_in        (bus.cmpVal),
    .period_in     (bus.period),
    .wrap_edge     (wrap_edge),
    .active_cmp    (active_cmp),
    .active_period (active_period)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sig_q  <= RESET_LEVEL;
      int_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_edge;
      if (bus.en) begin
        cnt_q <= wrap_edge ? '0 : cnt_q + 1'b1;
      end

      // PWM sets on the edge where cnt shows 0 after a wrap, so a match at 0 wins.
      if (match) begin
        case (mode_sel)
          MODE_TOGGLE: sig_q <= ~sig_q;
          MODE_SET:    sig_q <= 1'b1;
          MODE_CLEAR:  sig_q <= 1'b0;
          MODE_PWM:    sig_q <= 1'b0;
          default:     sig_q <= sig_q;
        endcase
      end else if (mode_sel == MODE_PWM && bus.en && wrap_q) begin
        sig_q <= 1'b1;
      end

      if (match) begin
        int_q <= 1'b1;
      end else if (bus.rstIntFlag) begin
        int_q <= 1'b0;
      end
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.sig     = sig_q;
  assign bus.intFlag = int_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_output_compare.sv
// tb/tb_output_compare.sv - scoreboard bench for output_compare
module tb_output_compare;

  localparam int K_CLR    = 0;
  localparam int K_WRAPS  = 1;
  localparam int K_HIGH   = 2;
  localparam int K_TOGGLE = 3;
  localparam int K_SIG    = 4;
  localparam int K_INT    = 5;
  localparam int K_BOUND  = 6;
  localparam int K_END    = 7;

  typedef struct packed {
    logic [7:0] cnt;
    logic       sig;
    logic       int_flag;
    logic       wrap;
  } exp_t;

  typedef struct {
    int    kind;
    int    value;
    string name;
  } dir_t;

  logic clk = 1'b0;
  logic rst;

  output_compare_if #(.WIDTH(8)) bus ();

  output_compare #(.WIDTH(8), .RESET_LEVEL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  dir_t dir_q[$];

  logic [7:0] m_cnt  = '0;
  logic       m_sig  = 1'b0;
  logic       m_int  = 1'b0;
  logic       m_wrap = 1'b0;
  logic [7:0] m_acmp = '0;
  logic [7:0] m_aper = '1;
  logic [7:0] m_pcmp = '0;
  logic [7:0] m_pper = '0;
  logic       m_pv   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_wraps   = 0;
  int obs_high    = 0;
  int obs_toggles = 0;
  logic obs_sig = 1'b0;
  logic obs_int = 1'b0;

  // Reference behaviour, evaluated before each rising edge with the inputs now applied.
  function automatic void model_step();
    logic at_end;
    logic hit;
    if (rst) begin
      m_cnt = '0; m_sig = 1'b0; m_int = 1'b0; m_wrap = 1'b0;
      m_acmp = '0; m_aper = '1; m_pv = 1'b0;
    end else begin
      at_end = bus.en && (m_cnt == m_aper);
      hit    = bus.en && (m_cnt == m_acmp);
      if (hit) begin
        case (bus.mode)
          2'b00:   m_sig = !m_sig;
          2'b01:   m_sig = 1'b1;
          default: m_sig = 1'b0;
        endcase
      end else if (bus.mode == 2'b11 && bus.en && m_wrap) begin
        m_sig = 1'b1;
      end
      if (hit) m_int = 1'b1;
      else if (bus.rstIntFlag) m_int = 1'b0;
      if (m_pv && (!bus.en || at_end)) begin
        m_acmp = m_pcmp; m_aper = m_pper; m_pv = 1'b0;
      end
      if (bus.load) begin
        m_pcmp = bus.cmpVal; m_pper = bus.period; m_pv = 1'b1;
      end
      if (bus.en) m_cnt = at_end ? 8'd0 : m_cnt + 8'd1;
      m_wrap = at_end;
    end
    exp_q.push_back({m_cnt, m_sig, m_int, m_wrap});
  endfunction

  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_dir(input int kind, input int value, input string name);
    dir_t d;
    d.kind = kind; d.value = value; d.name = name;
    dir_q.push_back(d);
  endtask

  task automatic run_until_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != 8'(target) && n < 300) begin
      step();
      n++;
    end
    if (m_cnt != 8'(target)) expect_dir(K_BOUND, target, "cnt_reach");
  endtask

  task automatic load_values(input int cmp, input int per);
    bus.cmpVal = 8'(cmp);
    bus.period = 8'(per);
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
  endtask

  // Monitor: pops one expectation per cycle, then services directed checks.
  always @(negedge clk) begin
    exp_t e;
    dir_t d;
    int   act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.cnt, bus.sig, bus.intFlag, bus.wrap} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got cnt=%0d sig=%b int=%b wrap=%b, want cnt=%0d sig=%b int=%b wrap=%b",
                 $time, bus.cnt, bus.sig, bus.intFlag, bus.wrap, e.cnt, e.sig, e.int_flag, e.wrap);
      end
    end
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      if (d.kind == K_CLR) begin
        obs_wraps = 0; obs_high = 0; obs_toggles = 0;
      end else if (d.kind == K_END) begin
        n_checks++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end else begin
        case (d.kind)
          K_WRAPS:  act = obs_wraps;
          K_HIGH:   act = obs_high;
          K_TOGGLE: act = obs_toggles;
          K_SIG:    act = int'(obs_sig);
          K_INT:    act = int'(obs_int);
          default:  act = -1;
        endcase
        n_checks++;
        if (act != d.value) begin
          n_fail++;
          $display("FAIL %s: got %0d, want %0d", d.name, act, d.value);
        end
      end
    end
    if (bus.wrap === 1'b1) obs_wraps++;
    if (bus.sig === 1'b1) obs_high++;
    if (bus.sig !== obs_sig) obs_toggles++;
    obs_sig = bus.sig;
    obs_int = bus.intFlag;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: summary not reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b1; bus.mode = 2'b00; bus.cmpVal = '0; bus.period = '0;
    bus.load = 1'b0; bus.rstIntFlag = 1'b0;
    @(negedge clk);
    #1;

    // Reset hold, then free run with default period 255.
    steps(5);
    rst = 1'b0;
    expect_dir(K_CLR, 0, "clr");
    steps(260);
    expect_dir(K_WRAPS, 1, "default_period_wraps");

    // Toggle mode, cmp=5 period=9.
    rst = 1'b1; step(); rst = 1'b0;
    bus.en = 1'b0; bus.mode = 2'b00;
    load_values(5, 9);
    step();
    bus.en = 1'b1;
    expect_dir(K_CLR, 0, "clr");
    steps(40);
    expect_dir(K_TOGGLE, 4, "toggle_count_40");
    expect_dir(K_INT, 1, "toggle_int_set");
    bus.rstIntFlag = 1'b1; step(); bus.rstIntFlag = 1'b0;
    expect_dir(K_INT, 0, "toggle_int_cleared");
    expect_dir(K_CLR, 0, "clr");
    steps(10);
    expect_dir(K_INT, 1, "toggle_int_reset_again");
    expect_dir(K_TOGGLE, 1, "toggle_count_10");

    // PWM, period=9 cmp=3.
    rst = 1'b1; step(); rst = 1'b0;
    bus.en = 1'b0; bus.mode = 2'b11;
    load_values(3, 9);
    step();
    bus.en = 1'b1;
    steps(20);
    expect_dir(K_CLR, 0, "clr");
    steps(10);
    expect_dir(K_HIGH, 3, "pwm_duty_3");

    // Mid-frame load at cnt=4 applies after the next wrap.
    run_until_cnt(4);
    load_values(7, 9);
    run_until_cnt(0);
    expect_dir(K_CLR, 0, "clr");
    steps(10);
    expect_dir(K_HIGH, 7, "pwm_duty_7_after_wrap");

    // Load on the wrap edge itself is deferred one frame.
    run_until_cnt(9);
    load_values(3, 9);
    expect_dir(K_CLR, 0, "clr");
    steps(10);
    expect_dir(K_HIGH, 7, "pwm_wrap_load_deferred");
    expect_dir(K_CLR, 0, "clr");
    steps(10);
    expect_dir(K_HIGH, 3, "pwm_wrap_load_applied");

    // cmp=0 holds low, cmp beyond period holds high.
    load_values(0, 9);
    steps(25);
    expect_dir(K_CLR, 0, "clr");
    steps(10);
    expect_dir(K_HIGH, 0, "pwm_cmp0_low");
    load_values(12, 9);
    steps(25);
    expect_dir(K_CLR, 0, "clr");
    steps(10);
    expect_dir(K_HIGH, 10, "pwm_cmp12_high");

    // Set mode, match coincident with rstIntFlag.
    rst = 1'b1; step(); rst = 1'b0;
    bus.en = 1'b0; bus.mode = 2'b01;
    load_values(2, 9);
    step();
    bus.en = 1'b1; bus.rstIntFlag = 1'b1;
    steps(3);
    expect_dir(K_SIG, 1, "set_mode_sig");
    expect_dir(K_INT, 1, "set_wins_over_clear");
    step();
    expect_dir(K_INT, 0, "clear_after_match");
    bus.rstIntFlag = 1'b0;

    // Reset with a pending load discards it.
    rst = 1'b1; step(); rst = 1'b0;
    bus.en = 1'b0; bus.mode = 2'b00;
    load_values(5, 9);
    step();
    bus.en = 1'b1;
    run_until_cnt(6);
    load_values(2, 4);
    rst = 1'b1; step(); rst = 1'b0;
    expect_dir(K_SIG, 0, "rst_mid_sig");
    expect_dir(K_INT, 0, "rst_mid_int");
    expect_dir(K_CLR, 0, "clr");
    steps(260);
    expect_dir(K_WRAPS, 1, "rst_discard_period_255");
    expect_dir(K_TOGGLE, 2, "rst_discard_cmp_0");

    expect_dir(K_END, 0, "end");
    @(negedge clk);
    @(negedge clk);
    $display("FAIL end: monitor did not finish");
    $fatal(1, "monitor did not finish");
  end

endmodule
